// File: rtl/phase_shift_divider.sv
// Programmable half-period divider with one-shot phase steps.
// Ports: clk_i/reset_i, enable_i, period_i, shift req/ack, phase, edge, offset.
module phase_shift_divider #(
  parameter  int CNT_WIDTH  = 7,
  parameter  int STEP       = 1,
  parameter  int MAX_OFFSET = 16,
  localparam int OFF_WIDTH  = $clog2(MAX_OFFSET + 1) + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic [CNT_WIDTH-1:0]        period_i,
  input  logic                        positiveShift_i,
  input  logic                        negativeShift_i,
  output logic                        shiftAck_o,
  output logic                        phasedSignal_o,
  output logic                        edge_o,
  output logic signed [OFF_WIDTH-1:0] offset_o,
  output logic                        offsetSat_o
);

  localparam int LW  = CNT_WIDTH + 2;
  localparam int OW1 = OFF_WIDTH + 1;

  localparam logic signed [LW-1:0] C_LMIN = LW'(2);
  localparam logic signed [LW-1:0] C_LMAX = LW'((2 ** CNT_WIDTH) - 1);
  localparam logic signed [LW-1:0] C_STEP = LW'(STEP);

  localparam logic signed [OW1-1:0] C_OMAX = OW1'(MAX_OFFSET);
  localparam logic signed [OW1-1:0] C_ONE  = OW1'(1);

  typedef enum logic [1:0] {
    P_NONE,
    P_POS,
    P_NEG
  } pend_t;

  pend_t r_pend, w_pend_nxt;

  logic [CNT_WIDTH-1:0]        r_cnt;
  logic [CNT_WIDTH-1:0]        r_cur_len;
  logic                        r_phase;
  logic                        r_edge;
  logic                        r_ack;
  logic signed [OFF_WIDTH-1:0] r_off;

  logic signed [LW-1:0]  w_base;
  logic signed [LW-1:0]  w_adj;
  logic [CNT_WIDTH-1:0]  w_cur_len;
  logic [CNT_WIDTH-1:0]  w_len_new;
  logic                  w_boundary;
  logic                  w_accept;
  logic                  w_apply;
  logic                  w_move_ok;
  logic signed [OW1-1:0] w_off_ext;
  logic signed [OW1-1:0] w_dir;
  logic signed [OW1-1:0] w_off_try;

  function automatic logic [CNT_WIDTH-1:0] f_clamp(
    input logic signed [LW-1:0] v
  );
    logic signed [LW-1:0] c;
    c = v;
    if (v < C_LMIN) c = C_LMIN;
    else if (v > C_LMAX) c = C_LMAX;
    return c[CNT_WIDTH-1:0];
  endfunction

  assign w_base = signed'({2'b00, period_i});

  // A cleared length register marks the first half-period after reset,
  // which runs on the live, clamped period_i.
  assign w_cur_len = (r_cur_len == '0) ? f_clamp(w_base) : r_cur_len;

  // >= keeps the counter from running away if the live length shrinks.
  assign w_boundary = enable_i &&
                      (r_cnt >= w_cur_len - CNT_WIDTH'(1));

  assign w_accept = (r_pend == P_NONE) &&
                    (positiveShift_i ^ negativeShift_i);

  assign w_off_ext = {r_off[OFF_WIDTH-1], r_off};
  assign w_dir     = (r_pend == P_POS) ? C_ONE : -C_ONE;
  assign w_off_try = w_off_ext + w_dir;
  assign w_move_ok = (w_off_try <= C_OMAX) && (w_off_try >= -C_OMAX);

  // Shift is discarded (no length change) if it would exceed the limit.
  assign w_apply = w_boundary && (r_pend != P_NONE) && w_move_ok;

  always_comb begin
    w_adj = '0;
    if (w_apply) w_adj = (r_pend == P_POS) ? -C_STEP : C_STEP;
  end

  assign w_len_new = f_clamp(w_base + w_adj);

  always_comb begin
    w_pend_nxt = r_pend;
    unique case (r_pend)
      P_NONE: begin
        if (w_accept)
          w_pend_nxt = positiveShift_i ? P_POS : P_NEG;
      end
      P_POS, P_NEG: begin
        if (w_boundary) w_pend_nxt = P_NONE;
      end
      default: w_pend_nxt = P_NONE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pend    <= P_NONE;
      r_cnt     <= '0;
      r_cur_len <= '0;
      r_phase   <= 1'b0;
      r_edge    <= 1'b0;
      r_ack     <= 1'b0;
      r_off     <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ack  <= w_accept;
      r_edge <= w_boundary;
      if (w_boundary) begin
        r_cnt     <= '0;
        r_phase   <= ~r_phase;
        r_cur_len <= w_len_new;
      end else if (enable_i) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_apply) r_off <= w_off_try[OFF_WIDTH-1:0];
    end
  end

  assign shiftAck_o     = r_ack;
  assign phasedSignal_o = r_phase;
  assign edge_o         = r_edge;
  assign offset_o       = r_off;
  assign offsetSat_o    = (w_off_ext == C_OMAX) || (w_off_ext == -C_OMAX);

endmodule

// File: tb/tb_phase_shift_divider.sv
// Scoreboard bench for phase_shift_divider against a countdown
// model of half-period lengths, pending shift and saturated offset.
module tb_phase_shift_divider;

  localparam int CW   = 7;
  localparam int STP  = 1;
  localparam int MAXO = 3;
  localparam int OW   = $clog2(MAXO + 1) + 1;

  logic                 clk_i = 1'b0;
  logic                 reset_i = 1'b1;
  logic                 enable_i = 1'b0;
  logic [CW-1:0]        period_i = '0;
  logic                 positiveShift_i = 1'b0;
  logic                 negativeShift_i = 1'b0;
  logic                 shiftAck_o;
  logic                 phasedSignal_o;
  logic                 edge_o;
  logic signed [OW-1:0] offset_o;
  logic                 offsetSat_o;

  phase_shift_divider #(
    .CNT_WIDTH (CW),
    .STEP      (STP),
    .MAX_OFFSET(MAXO)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .period_i       (period_i),
    .positiveShift_i(positiveShift_i),
    .negativeShift_i(negativeShift_i),
    .shiftAck_o     (shiftAck_o),
    .phasedSignal_o (phasedSignal_o),
    .edge_o         (edge_o),
    .offset_o       (offset_o),
    .offsetSat_o    (offsetSat_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit edg;
    bit ack;
    bit ph;
    int off;
    bit sat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Model: cycles left in current half-period, pending direction, offset.
  int m_left  = 0;
  int m_phase = 0;
  int m_off   = 0;
  int m_pend  = 0;
  bit m_first = 1'b1;

  int cur_per = 4;
  bit cur_en  = 1'b1;

  function automatic int clampl(input int v);
    if (v < 2) return 2;
    if (v > (1 << CW) - 1) return (1 << CW) - 1;
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model(input bit rst, input bit en, input bit pos,
                       input bit neg, input int per);
    exp_t e;
    bit   acc;
    int   adj;
    e.edg = 1'b0;
    e.ack = 1'b0;
    if (rst) begin
      m_left  = clampl(per);
      m_phase = 0;
      m_off   = 0;
      m_pend  = 0;
      m_first = 1'b1;
    end else begin
      acc = (m_pend == 0) && (pos != neg);
      if (en && m_left == 1) begin
        e.edg   = 1'b1;
        m_phase = 1 - m_phase;
        adj     = 0;
        if (m_pend != 0) begin
          if (iabs(m_off + m_pend) <= MAXO) begin
            m_off = m_off + m_pend;
            adj   = -m_pend * STP;
          end
          m_pend = 0;
        end
        m_left  = clampl(per + adj);
        m_first = 1'b0;
      end else if (en) begin
        m_left = m_left - 1;
      end
      if (acc) begin
        m_pend = pos ? 1 : -1;
        e.ack  = 1'b1;
      end
    end
    e.ph  = m_phase[0];
    e.off = m_off;
    e.sat = (iabs(m_off) == MAXO);
    q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit pos, input bit neg);
    @(negedge clk_i);
    reset_i         = rst;
    enable_i        = cur_en;
    period_i        = CW'(cur_per);
    positiveShift_i = pos;
    negativeShift_i = neg;
    model(rst, cur_en, pos, neg, cur_per);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d",
               nm, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("edge_o", int'(edge_o), int'(e.edg));
        chk("shiftAck_o", int'(shiftAck_o), int'(e.ack));
        chk("phasedSignal_o", int'(phasedSignal_o), int'(e.ph));
        chk("offset_o", int'(offset_o), e.off);
        chk("offsetSat_o", int'(offsetSat_o), int'(e.sat));
      end
    end
  end

  initial begin : stim
    int r;
    cur_per = 4;
    cur_en  = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    idle(20);
    drive(1'b0, 1'b1, 1'b0);
    idle(14);
    drive(1'b0, 1'b0, 1'b1);
    idle(14);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 1'b0);
      idle(9);
    end
    drive(1'b0, 1'b0, 1'b1);
    idle(12);
    drive(1'b0, 1'b1, 1'b1);
    idle(10);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    idle(12);
    idle(1);
    cur_en = 1'b0;
    idle(4);
    drive(1'b0, 1'b0, 1'b1);
    idle(5);
    cur_en = 1'b1;
    idle(12);
    cur_per = 1;
    idle(12);
    cur_per = 2;
    drive(1'b0, 1'b1, 1'b0);
    idle(10);
    cur_per = 127;
    drive(1'b0, 1'b0, 1'b1);
    idle(300);
    cur_per = 4;
    idle(130);
    drive(1'b0, 1'b1, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0);
    idle(20);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      cur_en = (r < 88);
      if (!m_first && $urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 19);
        cur_per = (r == 0) ? 127 : int'($urandom_range(1, 6));
      end
      if ($urandom_range(0, 699) == 0) begin
        drive(1'b1, 1'b0, 1'b0);
      end else begin
        r = $urandom_range(0, 15);
        drive(1'b0, r[3:2] == 2'b00 && r[0],
              r[3:2] == 2'b00 && r[1]);
      end
    end
    cur_en = 1'b1;
    idle(2);
    repeat (4) @(posedge clk_i);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
